tdc: RTL and testbench
======================

TDC -- requirements
Module: tdc

Interface
REQ-001 The parameters SHALL be: CLK_FREQ, default 200_000_000, clock frequency in Hz; BAUD, default 115200, UART bit rate.
REQ-002 Port `clk_200m` SHALL be an input, 1 bit wide: the single system clock; all logic is on its rising edge.
REQ-003 Port `rst_n` SHALL be an input, 1 bit wide: asynchronous, active-high reset (1 = reset asserted), despite the suffix.
REQ-004 Port `signal_in` SHALL be an input, 1 bit wide: asynchronous pulse input to be timed.
REQ-005 Port `uart_tx` SHALL be an output, 1 bit wide: UART serial output, 8N1, idle high.
REQ-006 Port `led` SHALL be an output, 4 bits wide: status indicators.

Function
REQ-007 `signal_in` SHALL pass through a 2-flop synchronizer; a rising edge is detected on the synchronized value (total 3-cycle input latency, identical for every edge).
REQ-008 A 32-bit cycle counter SHALL increment every clock; on each detected rising edge it SHALL restart at 1 on the next cycle, so the latched interval equals the number of clocks between edges.
REQ-009 On each rising edge after the first since reset, the counter value SHALL be latched as the measurement (edges 200 ns apart -> 40; 400 ns apart -> 80).
REQ-010 The first rising edge after reset SHALL only arm the TDC and produce no measurement.
REQ-011 The counter SHALL saturate at 0xFFFFFFFF; a saturated interval is reported as 0xFFFFFFFF.
REQ-012 Each measurement SHALL be written to a one-deep pending register; if the register is still full, the new value overwrites it and sets the sticky drop flag.
REQ-013 The transmit FSM SHALL cycle IDLE -> LOAD -> SEND -> IDLE; in IDLE with pending full, it takes the value, clears pending, and sends a frame.
REQ-014 A frame SHALL be 8 upper-case ASCII hex digits, MSB nibble first, followed by CR (0x0D) and LF (0x0A); 10 bytes total.
REQ-015 UART bit period SHALL be CLK_FREQ/BAUD clocks (integer division; 1736 at defaults), with 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1).
REQ-016 Consecutive bytes of a frame SHALL be sent back-to-back with no idle gap.
REQ-017 A measurement that coincides with the FSM taking pending SHALL be stored as the new pending value and SHALL NOT set the drop flag.
REQ-018 `led[0]` SHALL toggle on each measurement.
REQ-019 `led[1]` SHALL be 1 while a frame is being sent.
REQ-020 `led[2]` SHALL be the sticky drop flag.
REQ-021 `led[3]` SHALL be 1 once the TDC is armed.

Reset
REQ-022 While `rst_n` = 1, the design SHALL hold: uart_tx = 1, led = 4'b0000, counter = 0, pending empty, FSM IDLE, not armed, drop flag clear.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with `uart_tx` returning high asynchronously.

Configuration
REQ-024 With the macro `TDC_ASCII_EN` defined, frames SHALL be ASCII as in REQ-014.
REQ-025 Without `TDC_ASCII_EN`, a frame SHALL be 4 raw binary bytes, MSB first, with no CR/LF; all other behaviour is unchanged.

Structure
REQ-026 A package `tdc_pkg` SHALL hold COUNT_W = 32, the FSM state enum typedef, the CR/LF constants, and the frame-length constants for ASCII and binary modes.
REQ-027 The byte serializer SHALL be a sub-module `tdc_uart_tx` (inputs: byte plus valid; outputs: ready and serial line), parameterized by CLK_FREQ and BAUD.

Verification
REQ-028 Reset pulse of 20 ns, then idle -> uart_tx stays 1 and led = 0000.
REQ-029 Single rising edge at 1 ms -> led[3] = 1, no UART activity, led[0] unchanged.
REQ-030 Rising edges 200 ns apart -> frame "00000028\r\n" is decoded, led[0] toggles, and led[1] is high for the frame duration.
REQ-031 Edges at 1.0002 ms, 1.5003 ms and 1.5007 ms while the first frame is still sending -> 100020 is overwritten, the next frame is "00000050\r\n", and led[2] = 1.
REQ-032 A 100 ns pulse (shorter than one bit) is applied during a frame, with reset asserted mid-byte -> uart_tx = 1 immediately, and after release the next edge only re-arms.
REQ-033 Built without `TDC_ASCII_EN`, a 400 ns interval -> bytes 0x00 0x00 0x00 0x50.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and constants for the time-to-digital converter and its UART reporter.
package tdc_pkg;

  localparam int COUNT_W = 32;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int FRAME_LEN_ASCII = 10;
  localparam int FRAME_LEN_BIN   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } tx_state_t;

  // Upper-case ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/tdc_uart_tx.sv
// 8N1 byte serializer; ready rises in the last stop-bit cycle so bytes chain with no idle gap.
module tdc_uart_tx #(
  parameter int CLK_FREQ = 200_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CLKS - 1);

  logic          busy;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shift;
  logic          last_tick;

  assign last_tick = busy && (bit_idx == 4'd9) && (baud_cnt == BAUD_LAST);
  assign ready     = !busy || last_tick;

  // bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shift    <= '1;
      tx       <= 1'b1;
    end else if (valid && ready) begin
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shift    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (busy) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tdc.sv
// Pulse-interval TDC: measures clocks between rising edges of signal_in and reports them over UART.
// Define TDC_ASCII_EN for "XXXXXXXX\r\n" hex frames; otherwise 4 raw bytes, MSB first.
module tdc
  import tdc_pkg::*;
#(
  parameter int CLK_FREQ = 200_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_200m,
  input  logic       rst_n,
  input  logic       signal_in,
  output logic       uart_tx,
  output logic [3:0] led
);

`ifdef TDC_ASCII_EN
  localparam int FRAME_LEN = FRAME_LEN_ASCII;
`else
  localparam int FRAME_LEN = FRAME_LEN_BIN;
`endif
  localparam logic [3:0] FRAME_END = 4'(FRAME_LEN);

  logic               sync1, sync2, sync_prev;
  logic               edge_det;
  logic [COUNT_W-1:0] cnt;
  logic               armed;
  logic               meas;
  logic [COUNT_W-1:0] pending_data;
  logic               pending_full;
  logic               drop;
  logic               led_toggle;
  tx_state_t          state, state_next;
  logic               take;
  logic [COUNT_W-1:0] frame_data;
  logic [3:0]         byte_idx;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk_200m or posedge rst_n) begin
    if (rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= signal_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_det = sync2 && !sync_prev;
  assign meas     = edge_det && armed;

  // Restarting at 1 makes the value seen on the next edge equal the clock count between edges.
  always_ff @(posedge clk_200m or posedge rst_n) begin
    if (rst_n) begin
      cnt        <= '0;
      armed      <= 1'b0;
      led_toggle <= 1'b0;
    end else begin
      if (edge_det)       cnt <= COUNT_W'(1);
      else if (cnt != '1) cnt <= cnt + COUNT_W'(1);
      if (edge_det) armed <= 1'b1;
      if (meas)     led_toggle <= !led_toggle;
    end
  end

  // A new measurement wins over the FSM's take; it only counts as a drop if nobody took the old one.
  always_ff @(posedge clk_200m or posedge rst_n) begin
    if (rst_n) begin
      pending_data <= '0;
      pending_full <= 1'b0;
      drop         <= 1'b0;
    end else if (meas) begin
      pending_data <= cnt;
      pending_full <= 1'b1;
      if (pending_full && !take) drop <= 1'b1;
    end else if (take) begin
      pending_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_200m or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    tx_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending_full) begin
          take       = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_SEND;
      S_SEND: begin
        // Hold SEND until the last stop bit completes so led[1] covers the whole frame.
        if (byte_idx < FRAME_END) tx_valid = 1'b1;
        else if (tx_ready)        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_200m or posedge rst_n) begin
    if (rst_n) begin
      frame_data <= '0;
      byte_idx   <= 4'd0;
    end else begin
      if (take) frame_data <= pending_data;
      if (state == S_LOAD)             byte_idx <= 4'd0;
      else if (tx_valid && tx_ready)   byte_idx <= byte_idx + 4'd1;
    end
  end

  always_comb begin
    tx_data = 8'h00;
`ifdef TDC_ASCII_EN
    if (byte_idx == 4'd8)      tx_data = ASCII_CR;
    else if (byte_idx == 4'd9) tx_data = ASCII_LF;
    else                       tx_data = hex_char(frame_data[{3'd7 - byte_idx[2:0], 2'b00} +: 4]);
`else
    tx_data = frame_data[{2'd3 - byte_idx[1:0], 3'b000} +: 8];
`endif
  end

  tdc_uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart_tx (
    .clk  (clk_200m),
    .rst  (rst_n),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (uart_tx)
  );

  assign led = {armed, drop, (state != S_IDLE), led_toggle};

endmodule

// File: tb/tb_tdc.sv
// Bench for tdc: runs the UART fast (10 clocks per bit) and checks decoded frames against a cycle-stamped edge model.
`timescale 1ns/1ps
module tb_tdc;

  localparam int BIT = 10;
`ifdef TDC_ASCII_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 4;
`endif
  localparam int FRAME_CLKS = FLEN * 10 * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       signal_in;
  logic       uart_tx;
  logic [3:0] led;

  int checks = 0;
  int fails  = 0;

  tdc #(
    .CLK_FREQ(200_000_000),
    .BAUD    (20_000_000)
  ) dut (
    .clk_200m (clk),
    .rst_n    (rst),
    .signal_in(signal_in),
    .uart_tx  (uart_tx),
    .led      (led)
  );

  // clock / reset bookkeeping
  always #2.5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  int rst_cnt = 0;
  always @(posedge rst) rst_cnt++;

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // UART receiver: samples mid-bit on falling clock edges
  logic [7:0] rx_q[$];
  longint     start_q[$];
  int         framing_errs = 0;
  logic [7:0] mon_b;
  logic       mon_ok;
  logic       mon_stop;
  longint     mon_t0;
  int         mon_rst;

  always begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      mon_t0  = cyc;
      mon_rst = rst_cnt;
      mon_ok  = 1'b1;
      repeat (BIT / 2) @(negedge clk);
      if (uart_tx !== 1'b0) mon_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        mon_b[i] = uart_tx;
      end
      repeat (BIT) @(negedge clk);
      mon_stop = uart_tx;
      if (mon_ok && mon_rst == rst_cnt) begin
        rx_q.push_back(mon_b);
        start_q.push_back(mon_t0);
        if (mon_stop !== 1'b1) framing_errs++;
      end
    end
  end

  // reference model: measurement = clocks between driven rising edges
  logic [7:0]  exp_q[$];
  bit          armed_m;
  bit          led0_m;
  longint      last_cyc;
  logic [31:0] meas_val;
  bit          meas_ok;

  function automatic void push_frame(input logic [31:0] v);
`ifdef TDC_ASCII_EN
    string s;
    s = $sformatf("%08X", v);
    for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int i = 3; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
`endif
  endfunction

  // driver tasks (all begin and end right after a falling clock edge)
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    armed_m = 0;
    led0_m  = 0;
    rx_q.delete();
    start_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    signal_in = 1'b0;
    wait_n(4);
    rst = 1'b0;
    clear_model();
    wait_n(2);
  endtask

  task automatic rise(input int hold);
    longint diff;
    signal_in = 1'b1;
    meas_ok = 0;
    if (armed_m) begin
      diff = cyc - last_cyc;
      meas_val = (diff > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
      meas_ok = 1;
      led0_m = ~led0_m;
    end
    armed_m = 1;
    last_cyc = cyc;
    wait_n(hold);
    signal_in = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  // tests
  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    signal_in = 1'b0;
    #10;
    checks++;
    if (uart_tx !== 1'b1 || led !== 4'b0000) begin
      fails++;
      $display("FAIL reset_hold: uart_tx=%b led=%b, required 1 / 0000", uart_tx, led);
    end
    #10;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || led !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_idle: %0d cycles with uart_tx!=1 or led!=0000, required 0", bad);
    end
  endtask

  task automatic test_arm();
    int bad = 0;
    rise(2);
    wait_n(10);
    checks++;
    if (led !== 4'b1000) begin
      fails++;
      $display("FAIL arm_led: led=%b, required 1000", led);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL arm_quiet: %0d low cycles, %0d bytes, required 0 / 0", bad, rx_q.size());
    end
  endtask

  task automatic test_interval();
    do_reset();
    rise(2);
    wait_n(38);
    rise(2);
    if (meas_ok) push_frame(meas_val);
    wait_n(5);
    checks++;
    if (led[0] !== led0_m) begin
      fails++;
      $display("FAIL interval_led0: got %b, required %b", led[0], led0_m);
    end
    wait_n(5 * BIT);
    checks++;
    if (led[1] !== 1'b1) begin
      fails++;
      $display("FAIL interval_busy: led[1]=%b, required 1", led[1]);
    end
    wait_bytes(exp_q.size(), 2 * FRAME_CLKS);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL interval_len: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL interval_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]);
      end
    end
    for (int k = 1; k < start_q.size(); k++) begin
      checks++;
      if (start_q[k] - start_q[k-1] != 10 * BIT) begin
        fails++;
        $display("FAIL interval_spacing%0d: got %0d clocks, required %0d", k, start_q[k] - start_q[k-1], 10 * BIT);
      end
    end
    wait_n(BIT + 5);
    checks++;
    if (led[1] !== 1'b0 || led[2] !== 1'b0) begin
      fails++;
      $display("FAIL interval_after: led[2:1]=%b, required 00", led[2:1]);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    rise(2);
    wait_n(38);
    rise(2);
    push_frame(meas_val);
    wait_n(98);
    rise(2);
    wait_n(78);
    rise(2);
    push_frame(meas_val);
    wait_bytes(exp_q.size(), 3 * FRAME_CLKS);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL overwrite_len: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL overwrite_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (led[2] !== 1'b1) begin
      fails++;
      $display("FAIL overwrite_drop: led[2]=%b, required 1", led[2]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rise(2);
    for (int it = 0; it < 4; it++) begin
      int g1;
      wait_n($urandom_range(20, 300));
      rise(2);
      push_frame(meas_val);
      g1 = $urandom_range(3, 200);
      wait_n(g1 - 2);
      rise(2);
      push_frame(meas_val);
      wait_bytes(exp_q.size(), 3 * FRAME_CLKS);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_len: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d: got %02h, required %02h", i, rx_q[i], exp_q[i]);
      end
    end
    for (int k = 1; k < start_q.size(); k++) begin
      if (k % FLEN != 0) begin
        checks++;
        if (start_q[k] - start_q[k-1] != 10 * BIT) begin
          fails++;
          $display("FAIL b2b_spacing%0d: got %0d clocks, required %0d", k, start_q[k] - start_q[k-1], 10 * BIT);
        end
      end
    end
    wait_n(BIT + 5);
    checks++;
    if (led !== {1'b1, 1'b0, 1'b0, led0_m} || framing_errs != 0) begin
      fails++;
      $display("FAIL b2b_status: led=%b framing=%0d, required %b / 0", led, framing_errs, {3'b100, led0_m});
    end
  endtask

  task automatic test_reset_mid_frame();
    int t = 0;
    int bad = 0;
    do_reset();
    rise(2);
    wait_n(38);
    rise(2);
    while (uart_tx !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    wait_n(3);
    rise(20);
    checks++;
    if (uart_tx !== 1'b0) begin
      fails++;
      $display("FAIL midreset_prefix: uart_tx=%b mid-byte, required 0", uart_tx);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || led !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_async: uart_tx=%b led=%b, required 1 / 0000", uart_tx, led);
    end
    wait_n(4);
    rst = 1'b0;
    clear_model();
    wait_n(150);
    rx_q.delete();
    start_q.delete();
    rise(2);
    wait_n(10);
    checks++;
    if (led !== 4'b1000) begin
      fails++;
      $display("FAIL midreset_rearm: led=%b, required 1000", led);
    end
    for (int i = 0; i < FRAME_CLKS; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_quiet: %0d low cycles, %0d bytes, required 0 / 0", bad, rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_interval();
    test_overwrite();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
